// File: rtl/cylon_gen.sv
// Parametrised LED pattern generator: bounce, converge, bar-fill and blink modes with a
// carry-driven prescaler. Optional dim trail behind the mode-0 eye under CYLON_GEN_TRAIL_EN.
module cylon_gen #(
  parameter int NLED  = 8,
  parameter int MXPRE = 21,
  parameter int NRATE = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [NRATE-1:0] rate,
  output logic [NLED-1:0]  q,
  output logic             step,
  output logic             dbg_state_o
);

  localparam int PW = $clog2(NLED);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [MXPRE-1:0] pre_q, pre_d;
  logic [MXPRE:0]   pre_sum;
  logic [PW-1:0]    pos_q, pos_d, pos_nxt;
  logic             dir_up_q, dir_up_d, dir_up_nxt;
  logic [1:0]       mode_r_q;
  logic [NLED-1:0]  eye_q, eye_d;
  logic             step_q, step_d;
  logic             tick, mode_chg;

  function automatic logic [NLED-1:0] one_hot(input logic [PW-1:0] p);
    logic [NLED-1:0] r;
    r = '0;
    for (int i = 0; i < NLED; i++) r[i] = (p == PW'(i));
    return r;
  endfunction

  // Pattern shown for a given mode at position p; blink (mode 3) is handled by the caller.
  function automatic logic [NLED-1:0] pattern(input logic [1:0] m, input logic [PW-1:0] p);
    logic [NLED-1:0] r;
    r = '0;
    for (int i = 0; i < NLED; i++) begin
      case (m)
        2'd0:    r[i] = (p == PW'(i));
        2'd1:    r[i] = (p == PW'(i)) || (p == PW'(NLED - 1 - i));
        2'd2:    r[i] = (PW'(i) <= p);
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  // Tick is the carry out of the prescaler add, so every rate value produces one.
  assign pre_sum  = {1'b0, pre_q} + (MXPRE+1)'(rate) + (MXPRE+1)'(1);
  assign tick     = pre_sum[MXPRE] & enable;
  assign mode_chg = (mode != mode_r_q);

  // Position advance for a RUN tick; the direction flips on the tick that lands on an endpoint.
  always_comb begin
    pos_nxt    = pos_q;
    dir_up_nxt = dir_up_q;
    case (mode_r_q)
      2'd0, 2'd1: begin
        if (dir_up_q) begin
          pos_nxt = pos_q + PW'(1);
          if (pos_nxt == ((mode_r_q == 2'd0) ? PW'(NLED - 1) : PW'(NLED / 2 - 1))) dir_up_nxt = 1'b0;
        end else begin
          pos_nxt = pos_q - PW'(1);
          if (pos_nxt == '0) dir_up_nxt = 1'b1;
        end
      end
      2'd2:    pos_nxt = (pos_q == PW'(NLED - 1)) ? '0 : pos_q + PW'(1);
      default: pos_nxt = '0;
    endcase
  end

`ifdef CYLON_GEN_TRAIL_EN
  logic [1:0]      pwm_q;
  logic [NLED-1:0] trail_q, trail_d;
  logic [NLED-1:0] out_q;
`endif

  always_comb begin
    pre_d    = pre_q;
    pos_d    = pos_q;
    dir_up_d = dir_up_q;
    state_d  = state_q;
    eye_d    = eye_q;
    step_d   = 1'b0;
`ifdef CYLON_GEN_TRAIL_EN
    trail_d  = trail_q;
`endif
    if (enable) pre_d = pre_sum[MXPRE-1:0];
    if (mode_chg) begin
      // Mode switch wins over a coincident tick: back to lamp test, wait for a fresh tick.
      pos_d    = '0;
      dir_up_d = 1'b1;
      state_d  = S_INIT;
      eye_d    = {NLED{1'b1}};
`ifdef CYLON_GEN_TRAIL_EN
      trail_d  = '0;
`endif
    end else if (tick) begin
      step_d = 1'b1;
      if (state_q == S_INIT) begin
        state_d  = S_RUN;
        pos_d    = '0;
        dir_up_d = 1'b1;
        eye_d    = (mode_r_q == 2'd3) ? '0 : pattern(mode_r_q, '0);
`ifdef CYLON_GEN_TRAIL_EN
        trail_d  = '0;
`endif
      end else begin
        pos_d    = pos_nxt;
        dir_up_d = dir_up_nxt;
        eye_d    = (mode_r_q == 2'd3) ? ~eye_q : pattern(mode_r_q, pos_nxt);
`ifdef CYLON_GEN_TRAIL_EN
        trail_d  = (mode_r_q == 2'd0) ? one_hot(pos_q) : '0;
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q    <= '0;
      pos_q    <= '0;
      dir_up_q <= 1'b1;
      state_q  <= S_INIT;
      mode_r_q <= 2'd0;
      eye_q    <= {NLED{1'b1}};
      step_q   <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      pos_q    <= pos_d;
      dir_up_q <= dir_up_d;
      state_q  <= state_d;
      mode_r_q <= mode;
      eye_q    <= eye_d;
      step_q   <= step_d;
    end
  end

`ifdef CYLON_GEN_TRAIL_EN
  // Trail bit is lit only on pwm phase 0, giving a quarter-brightness afterglow.
  always_ff @(posedge clock) begin
    if (reset) begin
      pwm_q   <= 2'd0;
      trail_q <= '0;
      out_q   <= {NLED{1'b1}};
    end else begin
      pwm_q   <= pwm_q + 2'd1;
      trail_q <= trail_d;
      out_q   <= eye_d | (trail_d & {NLED{pwm_q == 2'd0}});
    end
  end
  assign q = out_q;
`else
  assign q = eye_q;
`endif

  assign step        = step_q;
  assign dbg_state_o = state_q;

endmodule
